i2c_target_eeprom_emu: RTL and testbench

// - I2C target (responder) emulating a 16-bit-addressed serial EEPROM. Pairs with our EEPROM I2C initiator.
// - Decodes START/STOP, device address, 2-byte register address, multi-byte write and sequential read.
// - Backs onto a synchronous byte memory port; used as an on-board EEPROM stand-in and as a bench model.

---
 rtl/i2c_target_eeprom_emu.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_target_eeprom_emu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_eeprom_emu.sv
// i2c_target_eeprom_emu: I2C target emulating a 16-bit-addressed serial EEPROM on a byte memory port.
// Optional write protect input i_wp is added when I2C_TGT_WP_EN is defined.
module i2c_target_eeprom_emu #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         MEM_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef I2C_TGT_WP_EN
    input  logic              i_wp,
`endif
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_oe,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_we,
    input  logic [7:0]        i_mem_rdata,
    output logic [31:0]       o_status
);
    localparam logic [4:0] IDLE    = 5'd0;
    localparam logic [4:0] DEVADDR = 5'd1;
    localparam logic [4:0] ACK_DEV = 5'd2;
    localparam logic [4:0] ADDR_H  = 5'd3;
    localparam logic [4:0] ACK_H   = 5'd4;
    localparam logic [4:0] ADDR_L  = 5'd5;
    localparam logic [4:0] ACK_L   = 5'd6;
    localparam logic [4:0] WR_BYTE = 5'd7;
    localparam logic [4:0] ACK_WR  = 5'd8;
    localparam logic [4:0] RD_LOAD = 5'd9;
    localparam logic [4:0] RD_BYTE = 5'd10;
    localparam logic [4:0] RD_MACK = 5'd11;

    logic wp;
`ifdef I2C_TGT_WP_EN
    assign wp = i_wp;
`else
    assign wp = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    // Both lines share the same synchronizer depth so their relative ordering is preserved.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
        end
    end

    assign scl       = scl_sync_q[SYNC_STAGES-1];
    assign sda       = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_prev_q;
    assign scl_fall  = ~scl & scl_prev_q;
    assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

    logic [4:0]        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d, tx_q, tx_d, addr_h_q, addr_h_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
    logic [7:0]        wdata_q, wdata_d, byte_cnt_q, byte_cnt_d;
    logic              rw_q, rw_d, sda_oe_q, sda_oe_d, we_q, we_d;
    logic              busy_q, busy_d, match_q, match_d, nack_q, nack_d;
    logic [15:0]       addr_full;
    logic              rx_state, byte_done, dev_hit;
    logic [7:0]        byte_cnt_inc;

    assign addr_full    = {addr_h_q, rx_q};
    assign rx_state     = state_q inside {DEVADDR, ADDR_H, ADDR_L, WR_BYTE};
    assign byte_done    = bit_cnt_q == 4'd8;
    assign dev_hit      = rx_q[7:1] == DEV_ADDR;
    assign byte_cnt_inc = byte_cnt_q + {7'd0, byte_cnt_q != 8'hff};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = state_q == RD_LOAD ? i_mem_rdata : tx_q;
        addr_h_d   = addr_h_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        we_d       = 1'b0;
        busy_d     = busy_q;
        match_d    = match_q;
        nack_d     = nack_q;
        byte_cnt_d = byte_cnt_q;
        mem_addr_d = ptr_q;
        wdata_d    = rx_q;
        if (start_det) begin
            state_d    = DEVADDR;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            match_d    = 1'b0;
            nack_d     = 1'b0;
            byte_cnt_d = 8'd0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            if (rx_state && !byte_done) begin
                rx_d      = {rx_q[6:0], sda};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            // Reads branch on the ACK rise so the first data bit can be driven on the ACK fall.
            if (state_q == ACK_DEV && rw_q) state_d = RD_LOAD;
            if (state_q == RD_MACK) begin
                state_d = sda ? IDLE : RD_LOAD;
                nack_d  = sda;
                ptr_d   = sda ? ptr_q : ptr_q + MEM_AW'(1);
            end
        end else if (scl_fall) begin
            case (state_q)
                DEVADDR: if (byte_done) begin
                    state_d  = dev_hit ? ACK_DEV : IDLE;
                    sda_oe_d = dev_hit;
                    match_d  = dev_hit;
                    rw_d     = rx_q[0];
                end
                ADDR_H: if (byte_done) begin
                    addr_h_d = rx_q;
                    state_d  = ACK_H;
                    sda_oe_d = 1'b1;
                end
                ADDR_L: if (byte_done) begin
                    ptr_d    = addr_full[MEM_AW-1:0];
                    state_d  = ACK_L;
                    sda_oe_d = 1'b1;
                end
                WR_BYTE: if (byte_done) begin
                    state_d  = ACK_WR;
                    sda_oe_d = ~wp;
                end
                ACK_DEV, ACK_H, ACK_L, ACK_WR: begin
                    state_d   = state_q == ACK_DEV ? ADDR_H : state_q == ACK_H ? ADDR_L : WR_BYTE;
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                    if (state_q == ACK_WR && !wp) begin
                        we_d       = 1'b1;
                        ptr_d      = ptr_q + MEM_AW'(1);
                        byte_cnt_d = byte_cnt_inc;
                    end
                end
                RD_LOAD: begin
                    state_d   = RD_BYTE;
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = ~tx_q[7];
                end
                RD_BYTE: if (bit_cnt_q == 4'd7) begin
                    state_d    = RD_MACK;
                    sda_oe_d   = 1'b0;
                    byte_cnt_d = byte_cnt_inc;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = {tx_q[6:0], 1'b0};
                    sda_oe_d  = ~tx_q[6];
                end
                default: ;
            endcase
        end
        if (state_d == IDLE) sda_oe_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            rx_q       <= 8'd0;
            tx_q       <= 8'd0;
            addr_h_q   <= 8'd0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
            nack_q     <= 1'b0;
            byte_cnt_q <= 8'd0;
            mem_addr_q <= '0;
            wdata_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_h_q   <= addr_h_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            match_q    <= match_d;
            nack_q     <= nack_d;
            byte_cnt_q <= byte_cnt_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign o_sda_oe    = sda_oe_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_we    = we_q;
    assign o_status    = {16'd0, byte_cnt_q, nack_q, state_q, match_q, busy_q};
endmodule

// File: tb/tb_i2c_target_eeprom_emu.sv
// tb_i2c_target_eeprom_emu: bit-banged I2C initiator with a byte-array EEPROM reference model.
module tb_i2c_target_eeprom_emu;
    localparam int Q = 6;
    logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic sda_bus, sda_oe, we;
    logic [7:0] maddr, wdata, rdata;
    logic [31:0] status;
`ifdef I2C_TGT_WP_EN
    logic wp = 1'b0;
`endif

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_eeprom_emu dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef I2C_TGT_WP_EN
        .i_wp(wp),
`endif
        .i_scl(scl_m),
        .i_sda(sda_bus),
        .o_sda_oe(sda_oe),
        .o_mem_addr(maddr),
        .o_mem_wdata(wdata),
        .o_mem_we(we),
        .i_mem_rdata(rdata),
        .o_status(status)
    );

    logic [7:0] mem [256];
    logic [7:0] we_log[$];
    bit init_done = 1'b0;
    int we_cnt = 0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            init_done <= 1'b1;
        end else if (we) begin
            mem[maddr] <= wdata;
            we_cnt <= we_cnt + 1;
            we_log.push_back(maddr);
        end
        rdata <= mem[maddr];
    end

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr = 8'd0;
    logic [7:0] dq[$];
    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bit_w(input logic b);
        sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
    endtask

    task automatic bit_r(output logic b);
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = sda_bus; q(); scl_m = 1'b0; q();
    endtask

    task automatic start_c();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q(); q();
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(b);
        ack = ~b;
    endtask

    task automatic byte_r(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        bit_w(~ack);
    endtask

    task automatic set_addr(input logic [15:0] a);
        logic ack;
        start_c();
        byte_w({7'h50, 1'b0}, ack); check("dev_w_ack", ack, 1);
        byte_w(a[15:8], ack);       check("addr_h_ack", ack, 1);
        byte_w(a[7:0], ack);        check("addr_l_ack", ack, 1);
        ref_ptr = a[7:0];
    endtask

    task automatic wr_txn(input logic [15:0] a, input logic [7:0] data[$]);
        logic ack;
        logic [7:0] exp_addr[$];
        int w0 = we_cnt;
        we_log.delete();
        set_addr(a);
        foreach (data[i]) begin
            byte_w(data[i], ack);
            check("wr_ack", ack, 1);
            ref_mem[ref_ptr] = data[i];
            exp_addr.push_back(ref_ptr);
            ref_ptr++;
        end
        stop_c();
        check("we_cnt", we_cnt - w0, data.size());
        if (we_log.size() == exp_addr.size())
            foreach (exp_addr[i]) check("we_addr", we_log[i], exp_addr[i]);
        check("wr_byte_cnt", status[15:8], data.size());
        check("wr_busy", status[0], 0);
    endtask

    task automatic rd_txn(input logic random_addr, input logic [15:0] a, input int n);
        logic ack;
        logic [7:0] d;
        if (random_addr) set_addr(a);
        start_c();
        byte_w({7'h50, 1'b1}, ack); check("dev_r_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            byte_r(i != n - 1, d);
            check("rd_data", d, ref_mem[ref_ptr]);
            if (i != n - 1) ref_ptr++;
        end
        stop_c();
        check("last_nack", status[7], 1);
        check("rd_byte_cnt", status[15:8], n);
        check("rd_busy", status[0], 0);
    endtask

    initial begin
        logic ack;
        int w0, diffs, op, n;
        logic [15:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (5) @(posedge clk);
        #1;
        check("rst_status", status, 0);
        check("rst_oe", sda_oe, 0);
        check("rst_we", we, 0);
        rst_n = 1'b1;
        q();

        dq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr_txn(16'h0012, dq);
        rd_txn(1'b1, 16'h0012, 4);

        w0 = we_cnt;
        start_c();
        byte_w({7'h51, 1'b0}, ack);
        check("bad_dev_ack", ack, 0);
        check("bad_dev_state", status[6:2], 0);
        check("bad_dev_match", status[1], 0);
        check("bad_dev_oe", sda_oe, 0);
        stop_c();
        check("bad_dev_we", we_cnt - w0, 0);

        dq = {8'($urandom), 8'($urandom)};
        wr_txn(16'h00FF, dq);
        rd_txn(1'b1, 16'h00FF, 2);

        w0 = we_cnt;
        set_addr(16'h0030);
        for (int i = 0; i < 4; i++) bit_w(1'($urandom));
        stop_c();
        check("partial_we", we_cnt - w0, 0);
        check("partial_busy", status[0], 0);
        check("partial_oe", sda_oe, 0);
        check("partial_state", status[6:2], 0);
        rd_txn(1'b0, 16'h0000, 2);

`ifdef I2C_TGT_WP_EN
        wp = 1'b1;
        w0 = we_cnt;
        set_addr(16'h0050);
        byte_w(8'h11, ack); check("wp_ack0", ack, 0);
        byte_w(8'h22, ack); check("wp_ack1", ack, 0);
        stop_c();
        check("wp_we", we_cnt - w0, 0);
        wp = 1'b0;
        rd_txn(1'b0, 16'h0000, 1);
`endif

        for (int it = 0; it < 10; it++) begin
            op = $urandom_range(0, 2);
            a = 16'($urandom);
            if (op == 0) begin
                n = $urandom_range(1, 5);
                dq.delete();
                for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
                wr_txn(a, dq);
            end else begin
                rd_txn(op == 1, a, $urandom_range(1, 4));
            end
        end

        dq = {8'h12};
        wr_txn(16'h0040, dq);
        set_addr(16'h0040);
        start_c();
        byte_w({7'h50, 1'b1}, ack);
        check("rst_rd_ack", ack, 1);
        check("rd_drive_low", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", sda_oe, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        q();
        check("post_rst_status", status, 0);
        ref_ptr = 8'd0;
        rd_txn(1'b0, 16'h0000, 2);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
